// File: rtl/reg_ctx_pkg.sv
// Shared types and constants for the register-context save/restore engine.
package reg_ctx_pkg;

    localparam int unsigned REG_IDX_W  = 4;
    localparam int unsigned WORD_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE_A  = 3'd1,
        SAVE_B  = 3'd2,
        RESTORE = 3'd3,
        FINISH  = 3'd4
    } ctx_state_t;

endpackage

// File: rtl/reg_ctx_engine_if.sv
// Control, register-file and memory signals of the context engine.
// master: the engine side; slave: the register file / memory / requester side.
interface reg_ctx_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) ();
    import reg_ctx_pkg::*;

    logic                 save;
    logic                 restore;
    logic [ADDR_W-1:0]    base_addr;
    logic                 busy;
    logic                 done;
    logic                 ctx_err;

    logic [REG_IDX_W-1:0] rf_src1;
    logic [REG_IDX_W-1:0] rf_src2;
    logic [DATA_W-1:0]    rf_data1;
    logic [DATA_W-1:0]    rf_data2;
    logic [REG_IDX_W-1:0] rf_dst;
    logic                 rf_we;
    logic [DATA_W-1:0]    rf_wdata;

    logic                 mem_en;
    logic                 mem_wr;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    modport master (
        input  save, restore, base_addr, rf_data1, rf_data2, mem_rdata,
        output busy, done, ctx_err, rf_src1, rf_src2, rf_dst, rf_we, rf_wdata,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output save, restore, base_addr, rf_data1, rf_data2, mem_rdata,
        input  busy, done, ctx_err, rf_src1, rf_src2, rf_dst, rf_we, rf_wdata,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ctx_addr_gen.sv
// Burst address generator: captures the word-aligned base, counts words and
// flags the final index of the current burst type.
module ctx_addr_gen
    import reg_ctx_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned EXTRA_WORDS = 0,
    parameter int unsigned CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic              restoreMode,
    input  logic [ADDR_W-1:0] baseIn,
    output logic [CNT_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic              lastIdx
);

    logic [ADDR_W-1:0] base;

    // Base capture (bit0 dropped) and per-cycle word index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
            idx  <= '0;
        end else if (start) begin
            base <= baseIn & ~ADDR_W'(1);
            idx  <= '0;
        end else if (advance) begin
            idx  <= idx + CNT_W'(1);
        end
    end

    // Address wraps modulo 2^ADDR_W by construction.
    assign addr = base + ADDR_W'(idx) * ADDR_W'(WORD_BYTES);

    // Restore runs one extra pipeline cycle beyond the last read.
    assign lastIdx = restoreMode ? (idx == CNT_W'(NUM_REGS + EXTRA_WORDS))
                                 : (idx == CNT_W'(NUM_REGS - 1 + EXTRA_WORDS));

endmodule

// File: rtl/reg_ctx_engine.sv
// Register-context save/restore engine: bursts the 16x16 register file to or
// from data memory while owning the register-file ports.
// Optional build macro CTX_CHECKSUM_EN appends an XOR checksum word.
module reg_ctx_engine
    import reg_ctx_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    reg_ctx_engine_if.master  bus
);

`ifdef CTX_CHECKSUM_EN
    localparam int unsigned EXTRA_WORDS = 1;
`else
    localparam int unsigned EXTRA_WORDS = 0;
`endif
    localparam int unsigned CNT_W = $clog2(NUM_REGS + 2);

    ctx_state_t        state;
    ctx_state_t        nextState;
    logic [CNT_W-1:0]  idx;
    logic [ADDR_W-1:0] wordAddr;
    logic              lastIdx;
    logic              startSave;
    logic              startRestore;
    logic              startAny;
    logic              advance;
    logic              memRead;
    logic              rfWrite;
    logic [DATA_W-1:0] hold;

    assign startSave    = (state == IDLE) && bus.save;
    assign startRestore = (state == IDLE) && !bus.save && bus.restore;
    assign startAny     = startSave || startRestore;
    assign advance      = (state == SAVE_A) || (state == SAVE_B) || (state == RESTORE);

    // Restore pipeline: read word k while writing register k-1 from last cycle's read.
    assign memRead = (state == RESTORE) && (idx <= CNT_W'(NUM_REGS - 1 + EXTRA_WORDS));
    assign rfWrite = (state == RESTORE) && (idx != '0) && (idx <= CNT_W'(NUM_REGS));

    ctx_addr_gen #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .EXTRA_WORDS (EXTRA_WORDS),
        .CNT_W       (CNT_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .start       (startAny),
        .advance     (advance),
        .restoreMode (state == RESTORE),
        .baseIn      (bus.base_addr),
        .idx         (idx),
        .addr        (wordAddr),
        .lastIdx     (lastIdx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Odd register of each pair is parked while the even one is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (state == SAVE_A) begin
            hold <= bus.rf_data2;
        end
    end

`ifdef CTX_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              ctxErr;

    // Running XOR of transferred words; error latched on the final compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum   <= '0;
            ctxErr <= 1'b0;
        end else if (startAny) begin
            csum   <= '0;
            ctxErr <= 1'b0;
        end else if (state == SAVE_A && !lastIdx) begin
            csum <= csum ^ bus.rf_data1 ^ bus.rf_data2;
        end else if (rfWrite) begin
            csum <= csum ^ bus.mem_rdata;
        end else if (state == RESTORE && lastIdx) begin
            ctxErr <= (bus.mem_rdata != csum);
        end
    end

    assign bus.ctx_err = ctxErr;
`else
    assign bus.ctx_err = 1'b0;
`endif

    // Next-state and port decode.
    always_comb begin
        nextState     = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.rf_src1   = '0;
        bus.rf_src2   = '0;
        bus.rf_dst    = '0;
        bus.rf_we     = 1'b0;
        bus.rf_wdata  = '0;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        case (state)
            IDLE: begin
                if (startSave) begin
                    nextState = SAVE_A;
                end else if (startRestore) begin
                    nextState = RESTORE;
                end
            end
            SAVE_A: begin
                bus.busy     = 1'b1;
                bus.rf_src1  = REG_IDX_W'(idx);
                bus.rf_src2  = REG_IDX_W'(idx) | REG_IDX_W'(1);
                bus.mem_en   = 1'b1;
                bus.mem_wr   = 1'b1;
                bus.mem_addr = wordAddr;
`ifdef CTX_CHECKSUM_EN
                bus.mem_wdata = lastIdx ? csum : bus.rf_data1;
`else
                bus.mem_wdata = bus.rf_data1;
`endif
                nextState = lastIdx ? FINISH : SAVE_B;
            end
            SAVE_B: begin
                bus.busy      = 1'b1;
                bus.rf_src1   = REG_IDX_W'(idx) & ~REG_IDX_W'(1);
                bus.rf_src2   = REG_IDX_W'(idx);
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = wordAddr;
                bus.mem_wdata = hold;
                nextState     = lastIdx ? FINISH : SAVE_A;
            end
            RESTORE: begin
                bus.busy = 1'b1;
                if (memRead) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = wordAddr;
                end
                if (rfWrite) begin
                    bus.rf_we    = 1'b1;
                    bus.rf_dst   = REG_IDX_W'(idx - CNT_W'(1));
                    bus.rf_wdata = bus.mem_rdata;
                end
                if (lastIdx) begin
                    nextState = FINISH;
                end
            end
            FINISH: begin
                bus.done  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine with a register-file and memory model.
// Expected latencies follow the CTX_CHECKSUM_EN build setting.
module tb_reg_ctx_engine;

`ifdef CTX_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [15:0] rf  [0:15];
    logic [15:0] mem [0:32767];
    logic [15:0] memRdata;

    logic        ldRfWe  = 1'b0;
    logic        ldMemWe = 1'b0;
    logic [3:0]  ldIdx   = '0;
    logic [15:0] ldAddr  = '0;
    logic [15:0] ldData  = '0;

    reg_ctx_engine_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    reg_ctx_engine #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rf_data1  = rf[bus.rf_src1];
    assign bus.rf_data2  = rf[bus.rf_src2];
    assign bus.mem_rdata = memRdata;

    // Register file and memory model, plus bench backdoor loading.
    always @(posedge clk) begin
        if (bus.rf_we)
            rf[bus.rf_dst] <= bus.rf_wdata;
        else if (ldRfWe)
            rf[ldIdx] <= ldData;
        if (bus.mem_en && bus.mem_wr)
            mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
        else if (ldMemWe)
            mem[ldAddr[15:1]] <= ldData;
        if (bus.mem_en && !bus.mem_wr)
            memRdata <= mem[bus.mem_addr[15:1]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic loadRf(input int idx, input int val);
        ldRfWe = 1'b1;
        ldIdx  = 4'(idx);
        ldData = 16'(val);
        tick();
        ldRfWe = 1'b0;
    endtask

    task automatic loadMem(input int addr, input int val);
        ldMemWe = 1'b1;
        ldAddr  = 16'(addr);
        ldData  = 16'(val);
        tick();
        ldMemWe = 1'b0;
    endtask

    // Ticks until done is seen; n = cycles waited, -1 on timeout.
    task automatic waitDone(output int n);
        n = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
            tick();
        end
    endtask

    task automatic startBurst(input logic doSave, input logic doRestore, input int base);
        bus.save      = doSave;
        bus.restore   = doRestore;
        bus.base_addr = 16'(base);
        tick();
        bus.save      = 1'b0;
        bus.restore   = 1'b0;
        bus.base_addr = 16'h0;
    endtask

    initial begin
        int n;
        int ck;
        logic sawDone;

        bus.save      = 1'b0;
        bus.restore   = 1'b0;
        bus.base_addr = 16'h0;
        tick();
        tick();

        check("reset_busy",    32'(bus.busy),     0);
        check("reset_done",    32'(bus.done),     0);
        check("reset_ctx_err", 32'(bus.ctx_err),  0);
        check("reset_mem_en",  32'(bus.mem_en),   0);
        check("reset_rf_we",   32'(bus.rf_we),    0);
        check("reset_addr",    32'(bus.mem_addr), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) loadRf(i, 'h1000 + i);
        ck = 0;
        for (int i = 0; i < 16; i++) begin
            loadMem('h0400 + 2 * i, 'hA5A0 + i);
            ck = ck ^ ('hA5A0 + i);
        end
        if (EXTRA == 1) loadMem('h0420, ck);

        // Save R0..R15 to 0x0200: one write per cycle T+1..T+16.
        startBurst(1'b1, 1'b0, 'h0200);
        ck = 0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("save_en[%0d]", i),    32'(bus.mem_en),    1);
            check($sformatf("save_wr[%0d]", i),    32'(bus.mem_wr),    1);
            check($sformatf("save_addr[%0d]", i),  32'(bus.mem_addr),  'h0200 + 2 * i);
            check($sformatf("save_wdata[%0d]", i), 32'(bus.mem_wdata), 'h1000 + i);
            check($sformatf("save_busy[%0d]", i),  32'(bus.busy),      1);
            ck = ck ^ ('h1000 + i);
            tick();
        end
        if (EXTRA == 1) begin
            check("save_csum_addr",  32'(bus.mem_addr),  'h0220);
            check("save_csum_wdata", 32'(bus.mem_wdata), ck);
            tick();
        end
        check("save_done",       32'(bus.done),   1);
        check("save_done_busy",  32'(bus.busy),   0);
        check("save_done_memen", 32'(bus.mem_en), 0);
        tick();
        check("save_done_pulse", 32'(bus.done),   0);
        check("save_mem_first",  32'(mem[15'('h0100)]), 'h1000);
        check("save_mem_last",   32'(mem[15'('h010F)]), 'h100F);

        // Restore from 0x0400: rf_we in T+2..T+17, done at T+18.
        startBurst(1'b0, 1'b1, 'h0400);
        check("rst_k0_en",   32'(bus.mem_en),   1);
        check("rst_k0_wr",   32'(bus.mem_wr),   0);
        check("rst_k0_addr", 32'(bus.mem_addr), 'h0400);
        check("rst_k0_we",   32'(bus.rf_we),    0);
        for (int k = 1; k <= 16 + EXTRA; k++) begin
            tick();
            if (k <= 16) begin
                check($sformatf("rst_we[%0d]", k),    32'(bus.rf_we),    1);
                check($sformatf("rst_dst[%0d]", k),   32'(bus.rf_dst),   k - 1);
                check($sformatf("rst_wdata[%0d]", k), 32'(bus.rf_wdata), 'hA5A0 + k - 1);
            end else begin
                check("rst_csum_we", 32'(bus.rf_we), 0);
            end
            if (k < 16 + EXTRA) begin
                check($sformatf("rst_en[%0d]", k),   32'(bus.mem_en),   1);
                check($sformatf("rst_addr[%0d]", k), 32'(bus.mem_addr), 'h0400 + 2 * k);
            end else begin
                check("rst_last_en", 32'(bus.mem_en), 0);
            end
        end
        tick();
        check("rst_done",    32'(bus.done),    1);
        check("rst_done_we", 32'(bus.rf_we),   0);
        check("rst_ctx_err", 32'(bus.ctx_err), 0);
        tick();
        check("rst_rf0",  32'(rf[0]),  'hA5A0);
        check("rst_rf7",  32'(rf[7]),  'hA5A7);
        check("rst_rf15", 32'(rf[15]), 'hA5AF);

`ifdef CTX_CHECKSUM_EN
        // Corrupted word 3 must flag ctx_err; the next clean restore clears it.
        loadMem('h0206, 'hDEAD);
        startBurst(1'b0, 1'b1, 'h0200);
        waitDone(n);
        check("csum_bad_lat", n, 18);
        check("csum_bad_err", 32'(bus.ctx_err), 1);
        tick();
        startBurst(1'b0, 1'b1, 'h0400);
        check("csum_clr_start", 32'(bus.ctx_err), 0);
        waitDone(n);
        check("csum_ok_lat", n, 18);
        check("csum_ok_err", 32'(bus.ctx_err), 0);
        tick();
`endif

        // save+restore together: save wins; restore during busy ignored.
        startBurst(1'b1, 1'b1, 'h0600);
        check("both_wr",   32'(bus.mem_wr),   1);
        check("both_addr", 32'(bus.mem_addr), 'h0600);
        tick();
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        waitDone(n);
        check("both_lat", n, 14 + EXTRA);
        tick();
        check("busy_req_ignored",  32'(bus.busy),   0);
        check("busy_req_no_mem",   32'(bus.mem_en), 0);
        check("both_mem",          32'(mem[15'('h0305)]), 'hA5A5);

        startBurst(1'b1, 1'b0, 'h0700);
        check("fresh_busy", 32'(bus.busy),     1);
        check("fresh_addr", 32'(bus.mem_addr), 'h0700);
        waitDone(n);
        check("fresh_lat", n, 16 + EXTRA);
        tick();

        // Address wrap past 0xFFFE.
        startBurst(1'b1, 1'b0, 'hFFFC);
        check("wrap_a0", 32'(bus.mem_addr), 'hFFFC);
        tick();
        check("wrap_a1", 32'(bus.mem_addr), 'hFFFE);
        tick();
        check("wrap_a2", 32'(bus.mem_addr), 'h0000);
        tick();
        check("wrap_a3", 32'(bus.mem_addr), 'h0002);
        waitDone(n);
        check("wrap_lat", n, 13 + EXTRA);
        tick();
        check("wrap_mem_hi", 32'(mem[15'('h7FFE)]), 'hA5A0);
        check("wrap_mem_lo", 32'(mem[15'('h0001)]), 'hA5A3);

        // Odd base is aligned down.
        startBurst(1'b1, 1'b0, 'h0201);
        check("odd_a0", 32'(bus.mem_addr), 'h0200);
        tick();
        check("odd_a1", 32'(bus.mem_addr), 'h0202);
        waitDone(n);
        check("odd_lat", n, 15 + EXTRA);
        tick();

        // Reset during the 5th write of a save.
        startBurst(1'b1, 1'b0, 'h0800);
        tick();
        tick();
        tick();
        tick();
        check("abort_pre_addr", 32'(bus.mem_addr), 'h0808);
        rst = 1'b1;
        #1;
        check("abort_busy",   32'(bus.busy),      0);
        check("abort_done",   32'(bus.done),      0);
        check("abort_mem_en", 32'(bus.mem_en),    0);
        check("abort_mem_wr", 32'(bus.mem_wr),    0);
        check("abort_addr",   32'(bus.mem_addr),  0);
        check("abort_wdata",  32'(bus.mem_wdata), 0);
        check("abort_rf_we",  32'(bus.rf_we),     0);
        check("abort_src1",   32'(bus.rf_src1),   0);
        check("abort_err",    32'(bus.ctx_err),   0);
        tick();
        rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) sawDone = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(sawDone), 0);

        startBurst(1'b1, 1'b0, 'h0900);
        waitDone(n);
        check("post_abort_lat", n, 16 + EXTRA);
        tick();
        check("post_abort_mem", 32'(mem[15'('h0489)]), 'hA5A9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_ctx_engine.md
Name: reg_ctx_engine

Overview:
- Initiator-side master for the 16x16 RegisterFile: drives its SrcReg1/SrcReg2 read ports and its DstReg/WriteReg/DstData write port.
- Saves the full register context to data memory, or restores it from memory, as a self-timed burst.
- Sits beside the pipeline and owns the register-file ports while busy; used for context switch and for bench dump/load.

Parameters:
NUM_REGS, 16, registers transferred per burst (even, ≤16)
DATA_W, 16, register/memory word width
ADDR_W, 16, byte address width (one word = 2 bytes)

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  asynchronous, active-high reset
save  in  1  start save burst (sampled in IDLE)
restore  in  1  start restore burst (sampled in IDLE)
base_addr  in  ADDR_W  context base byte address, captured at start
busy  out  1  high while a burst is active
done  out  1  one-cycle pulse at burst completion
ctx_err  out  1  checksum mismatch flag (feature only; else tied 0)
rf_src1  out  4  RegisterFile SrcReg1
rf_src2  out  4  RegisterFile SrcReg2
rf_data1  in  DATA_W  RegisterFile SrcData1 (combinational read)
rf_data2  in  DATA_W  RegisterFile SrcData2 (combinational read)
rf_dst  out  4  RegisterFile DstReg
rf_we  out  1  RegisterFile WriteReg
rf_wdata  out  DATA_W  RegisterFile DstData
mem_en  out  1  memory access enable
mem_wr  out  1  1=write, 0=read (valid with mem_en)
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid the cycle after a read is issued

Behaviour:
- Reset (async, any time, including mid-burst): state IDLE; busy, done, ctx_err, mem_en, mem_wr, rf_we = 0; all address/data outputs = 0; no done pulse for the aborted burst.
- Start: in IDLE, save=1 starts SAVE; else restore=1 starts RESTORE. If both are high, save wins. Requests while busy are ignored, not queued.
- base_addr is captured at start with bit0 forced 0. Word i is at base+2*i, modulo 2^ADDR_W (wraps silently).
- States: IDLE, SAVE_A, SAVE_B, RESTORE, FINISH.
- SAVE_A, pair index p: rf_src1=2p, rf_src2=2p+1. Write word 2p from rf_data1 (mem_en=1, mem_wr=1). Latch rf_data2 into a hold register. Go to SAVE_B.
- SAVE_B: write word 2p+1 from the hold register. Next state is SAVE_A for p+1, or FINISH after the last pair.
- SAVE timing: accept at edge T; memory writes in cycles T+1..T+NUM_REGS, one word per cycle with no gaps; FINISH cycle = T+NUM_REGS+1.
- RESTORE is pipelined, counter k = 0..NUM_REGS:
  - For k<NUM_REGS: issue read of word k (mem_en=1, mem_wr=0).
  - For k≥1: rf_we=1, rf_dst=k-1, rf_wdata=mem_rdata.
  - Occupies NUM_REGS+1 cycles, then FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. A new request is accepted no earlier than the cycle after FINISH.
- busy is high in every non-IDLE, non-FINISH state.
- rf_we is never asserted outside RESTORE. mem_en is never asserted in IDLE or FINISH.

Optional Feature:
- Macro CTX_CHECKSUM_EN.
- With the macro:
  - SAVE appends one extra write at word NUM_REGS holding the XOR of all saved words (+1 cycle).
  - RESTORE issues one extra read of that word and compares it against the XOR of the restored words.
  - ctx_err is set on mismatch at FINISH and cleared at the next accepted start.
- Without the macro: no extra word, no extra cycle, ctx_err tied 0.

Decomposition:
- Shared package reg_ctx_pkg holds:
  - state enum ctx_state_t {IDLE, SAVE_A, SAVE_B, RESTORE, FINISH}
  - constants REG_IDX_W=4 and WORD_BYTES=2
- One sub-module, ctx_addr_gen: base capture, index counter and address computation, with a last-index flag. All else lives in the top-level FSM.

Test Plan:
- Load R0..R15 = 16'h1000+i, base=16'h0200, pulse save → writes 0x1000..0x100F to 0x0200..0x021E in consecutive cycles T+1..T+16; done at T+17.
- Memory 0x0400..0x041E = 16'hA5A0+i, pulse restore → Ri = 16'hA5A0+i; rf_we high in cycles T+2..T+17; done at T+18.
- save and restore high together in IDLE → save burst only; restore pulse during busy → ignored; after done, a fresh save is accepted.
- base=16'hFFFC → words land at 0xFFFC, 0xFFFE, 0x0000 …; base=16'h0201 → treated as 0x0200.
- Assert rst at the 5th write of a save → all outputs 0 immediately, no done pulse; a subsequent save completes normally.
- CTX_CHECKSUM_EN: save then restore with word 3 corrupted to 16'hDEAD → ctx_err=1 at FINISH; an uncorrupted restore leaves ctx_err=0.
